// File: rtl/mem_loader_if.sv
// Byte-stream handshake plus RAM write port of the boot loader.
// The slave modport is the loader side; master is the stream source / RAM side.
interface mem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_we, mem_wd
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: packs a LEN-prefixed byte stream into little-endian words and releases the core once written.
// Optional trailing XOR checksum byte is enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_SIZE  = 4096
) (
  input  logic         clk,
  input  logic         rst,
  mem_loader_if.slave  bus,
  output logic         core_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    INIT,
    HDR,
    DATA,
`ifdef MEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [1:0]  hdr_cnt;
  logic [31:0] len;
  logic [31:0] cnt;
  logic [31:0] word;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        xfer;
  logic [31:0] len_next;
  logic [31:0] cnt_next;
  logic [31:0] word_next;
  logic        last;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign len_next  = {bus.in_data, len[31:8]};
  assign cnt_next  = cnt + 32'd1;
  // Lane is the low two bits of the byte count; words always start lane-aligned.
  assign word_next = word | ({24'd0, bus.in_data} << {cnt[1:0], 3'b000});
  assign last      = (cnt_next == len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      bus.in_ready <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= BASE_ADDR;
      bus.mem_wd   <= '0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      hdr_cnt      <= '0;
      len          <= '0;
      cnt          <= '0;
      word         <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        INIT: begin
          state        <= HDR;
          bus.in_ready <= 1'b1;
          busy         <= 1'b1;
        end
        HDR: if (xfer) begin
          len     <= len_next;
          hdr_cnt <= hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd3) begin
            if (len_next == '0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              state        <= CSUM;
`else
              state        <= DONE;
              bus.in_ready <= 1'b0;
`endif
            end else if (len_next > 32'(MEM_SIZE)) begin
              state        <= ERR;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              err          <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: if (xfer) begin
          cnt <= cnt_next;
`ifdef MEM_LOADER_CHECKSUM_EN
          csum <= csum ^ bus.in_data;
`endif
          // A full word or the tail of the image flushes while the next byte keeps flowing.
          if (cnt[1:0] == 2'd3 || last) begin
            bus.mem_we   <= 1'b1;
            bus.mem_wd   <= word_next;
            bus.mem_addr <= BASE_ADDR + {cnt[31:2], 2'b00};
            word         <= '0;
          end else begin
            word <= word_next;
          end
          if (last) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            state        <= CSUM;
`else
            state        <= DONE;
            bus.in_ready <= 1'b0;
`endif
          end
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        CSUM: if (xfer) begin
          bus.in_ready <= 1'b0;
          if (bus.in_data == csum) begin
            state <= DONE;
          end else begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
        end
`endif
        // Core release lands one cycle after entry, so it never coincides with the last write.
        DONE: begin
          busy       <= 1'b0;
          done       <= 1'b1;
          core_rst_n <= 1'b1;
        end
        ERR: begin
          busy <= 1'b0;
          err  <= 1'b1;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader; recompile with MEM_LOADER_CHECKSUM_EN to cover the checksum build.
module tb_mem_loader;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          MSZ  = 4096;
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam int DLAT = 2;
`else
  localparam int DLAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst_n, busy, done, err;

  mem_loader_if ifc();

  mem_loader #(.BASE_ADDR(BASE), .MEM_SIZE(MSZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int done_cyc = -1;
  int crst_cyc = -1;
  int overlap  = 0;
  logic [7:0] strm[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ifc.mem_we === 1'b1) begin
      wr_addr.push_back(ifc.mem_addr);
      wr_data.push_back(ifc.mem_wd);
      wr_cyc.push_back(cyc);
      if (core_rst_n === 1'b1) overlap++;
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    if (core_rst_n === 1'b1 && crst_cyc < 0) crst_cyc = cyc;
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc = -1;
    crst_cyc = -1;
    rst = 1'b0;
  endtask

  task automatic push_len(input logic [31:0] l);
    for (int i = 0; i < 4; i++) strm.push_back(l[8*i +: 8]);
  endtask

  task automatic push_csum(input logic [7:0] c);
`ifdef MEM_LOADER_CHECKSUM_EN
    strm.push_back(c);
`else
    if (c === 8'hxx) strm.push_back(c);
`endif
  endtask

  task automatic send_stream(input bit gaps, output bit ok);
    bit got;
    ok = 1'b1;
    for (int i = 0; i < strm.size(); i++) begin
      got = 1'b0;
      if (gaps && i > 0) begin
        @(negedge clk);
        ifc.in_valid = 1'b0;
      end
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data  = strm[i];
        if (ifc.in_ready === 1'b1) got = 1'b1;
      end
      if (!got) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    strm.delete();
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", ifc.in_ready); end
    checks++; if (ifc.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0b exp=0", ifc.mem_we); end
    checks++; if (ifc.mem_addr !== BASE) begin failures++; $display("FAIL rst_mem_addr got=%h exp=%h", ifc.mem_addr, BASE); end
    checks++; if (ifc.mem_wd !== 32'h0) begin failures++; $display("FAIL rst_mem_wd got=%h exp=0", ifc.mem_wd); end
    checks++; if ({core_rst_n, busy, done, err} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {core_rst_n, busy, done, err}); end
    do_reset();
    @(negedge clk);
    checks++; if ({busy, ifc.in_ready} !== 2'b11) begin failures++; $display("FAIL init_to_hdr busy/ready got=%b exp=11", {busy, ifc.in_ready}); end
  endtask

  task automatic test_len8;
    bit ok, fin;
    do_reset();
    push_len(32'd8);
    foreach (strm[i]) ;
    strm.push_back(8'h13); strm.push_back(8'h00); strm.push_back(8'h00); strm.push_back(8'h00);
    strm.push_back(8'h6F); strm.push_back(8'h00); strm.push_back(8'h00); strm.push_back(8'h00);
    push_csum(8'h7C);
    send_stream(1'b0, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL len8_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL len8_wcount got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== BASE || wr_data[0] !== 32'h0000_0013) begin failures++; $display("FAIL len8_w0 got=%h@%h exp=00000013@%h", wr_data[0], wr_addr[0], BASE); end
      checks++; if (wr_addr[1] !== BASE + 32'd4 || wr_data[1] !== 32'h0000_006F) begin failures++; $display("FAIL len8_w1 got=%h@%h exp=0000006f@%h", wr_data[1], wr_addr[1], BASE + 32'd4); end
      checks++; if (done_cyc - wr_cyc[1] !== DLAT) begin failures++; $display("FAIL len8_done_lat got=%0d exp=%0d", done_cyc - wr_cyc[1], DLAT); end
      checks++; if (crst_cyc - wr_cyc[1] !== DLAT) begin failures++; $display("FAIL len8_crst_lat got=%0d exp=%0d", crst_cyc - wr_cyc[1], DLAT); end
    end
  endtask

  task automatic test_len5;
    bit ok, fin;
    do_reset();
    push_len(32'd5);
    strm.push_back(8'h11); strm.push_back(8'h22); strm.push_back(8'h33);
    strm.push_back(8'h44); strm.push_back(8'h55);
    push_csum(8'h11);
    send_stream(1'b0, ok);
    checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL len5_ready_drop got=%0b exp=0", ifc.in_ready); end
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL len5_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL len5_wcount got=%0d exp=2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== BASE || wr_data[0] !== 32'h4433_2211) begin failures++; $display("FAIL len5_w0 got=%h@%h exp=44332211@%h", wr_data[0], wr_addr[0], BASE); end
      checks++; if (wr_addr[1] !== BASE + 32'd4 || wr_data[1] !== 32'h0000_0055) begin failures++; $display("FAIL len5_w1 got=%h@%h exp=00000055@%h", wr_data[1], wr_addr[1], BASE + 32'd4); end
    end
    checks++; if ({done, core_rst_n, busy, err} !== 4'b1100) begin failures++; $display("FAIL len5_flags got=%b exp=1100", {done, core_rst_n, busy, err}); end
  endtask

  task automatic test_len_zero;
    bit ok, fin;
    do_reset();
    push_len(32'd0);
    push_csum(8'h00);
    send_stream(1'b0, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL len0_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL len0_wcount got=%0d exp=0", wr_addr.size()); end
    checks++; if ({done, core_rst_n, err} !== 3'b110) begin failures++; $display("FAIL len0_flags got=%b exp=110", {done, core_rst_n, err}); end
  endtask

  task automatic test_oversize;
    bit ok, fin;
    do_reset();
    push_len(32'(MSZ + 4));
    send_stream(1'b0, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL big_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if ({err, done, core_rst_n, busy, ifc.in_ready} !== 5'b10000) begin failures++; $display("FAIL big_flags got=%b exp=10000", {err, done, core_rst_n, busy, ifc.in_ready}); end
    checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL big_wcount got=%0d exp=0", wr_addr.size()); end
    strm.push_back(8'hAA);
    send_stream(1'b0, ok);
    checks++; if (ok !== 1'b0) begin failures++; $display("FAIL big_accepts_after_err got=%0b exp=0", ok); end
  endtask

  task automatic test_gaps;
    bit ok, fin;
    do_reset();
    push_len(32'd4);
    strm.push_back(8'h01); strm.push_back(8'h02); strm.push_back(8'h03); strm.push_back(8'h04);
    push_csum(8'h04);
    send_stream(1'b1, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL gap_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL gap_wcount got=%0d exp=1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      checks++; if (wr_addr[0] !== BASE || wr_data[0] !== 32'h0403_0201) begin failures++; $display("FAIL gap_w0 got=%h@%h exp=04030201@%h", wr_data[0], wr_addr[0], BASE); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gap_done got=%0b exp=1", done); end
  endtask

  task automatic test_reset_mid;
    bit ok, fin;
    do_reset();
    push_len(32'd4);
    strm.push_back(8'h12); strm.push_back(8'h34);
    send_stream(1'b0, ok);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({core_rst_n, busy, ifc.in_ready, ifc.mem_we} !== 4'b0000) begin failures++; $display("FAIL mid_rst_flags got=%b exp=0000", {core_rst_n, busy, ifc.in_ready, ifc.mem_we}); end
    checks++; if (ifc.mem_addr !== BASE) begin failures++; $display("FAIL mid_rst_addr got=%h exp=%h", ifc.mem_addr, BASE); end
    do_reset();
    push_len(32'd4);
    strm.push_back(8'hAA); strm.push_back(8'hBB); strm.push_back(8'hCC); strm.push_back(8'hDD);
    push_csum(8'h00);
    send_stream(1'b0, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL mid_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL mid_wcount got=%0d exp=1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      checks++; if (wr_addr[0] !== BASE || wr_data[0] !== 32'hDDCC_BBAA) begin failures++; $display("FAIL mid_w0 got=%h@%h exp=ddccbbaa@%h", wr_data[0], wr_addr[0], BASE); end
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mid_done got=%0b exp=1", done); end
  endtask

  task automatic test_full_size;
    bit ok, fin;
    do_reset();
    push_len(32'(MSZ));
    for (int i = 0; i < MSZ; i++) strm.push_back(8'(i));
    push_csum(8'h00);
    send_stream(1'b0, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL full_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if (wr_addr.size() !== MSZ / 4) begin failures++; $display("FAIL full_wcount got=%0d exp=%0d", wr_addr.size(), MSZ / 4); end
    if (wr_addr.size() == MSZ / 4) begin
      checks++; if (wr_addr[0] !== BASE || wr_data[0] !== 32'h0302_0100) begin failures++; $display("FAIL full_first got=%h@%h exp=03020100@%h", wr_data[0], wr_addr[0], BASE); end
      checks++; if (wr_addr[MSZ/4-1] !== BASE + 32'(MSZ - 4) || wr_data[MSZ/4-1] !== 32'hFFFE_FDFC) begin failures++; $display("FAIL full_last got=%h@%h exp=fffefdfc@%h", wr_data[MSZ/4-1], wr_addr[MSZ/4-1], BASE + 32'(MSZ - 4)); end
    end
    checks++; if ({done, err} !== 2'b10) begin failures++; $display("FAIL full_flags got=%b exp=10", {done, err}); end
  endtask

`ifdef MEM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    bit ok, fin;
    do_reset();
    push_len(32'd2);
    strm.push_back(8'h0F); strm.push_back(8'hF0); strm.push_back(8'hFF);
    send_stream(1'b0, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL csum_ok_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if ({done, core_rst_n, err} !== 3'b110) begin failures++; $display("FAIL csum_ok_flags got=%b exp=110", {done, core_rst_n, err}); end
    checks++; if (wr_data.size() !== 1 || wr_data[0] !== 32'h0000_F00F) begin failures++; $display("FAIL csum_ok_write got n=%0d exp n=1 data=0000f00f", wr_data.size()); end
    do_reset();
    push_len(32'd2);
    strm.push_back(8'h0F); strm.push_back(8'hF0); strm.push_back(8'h00);
    send_stream(1'b0, ok);
    wait_end(fin);
    checks++; if (!(ok && fin)) begin failures++; $display("FAIL csum_bad_stream got ok=%0b fin=%0b exp=1/1", ok, fin); end
    checks++; if ({err, done, core_rst_n} !== 3'b100) begin failures++; $display("FAIL csum_bad_flags got=%b exp=100", {err, done, core_rst_n}); end
    checks++; if (wr_addr.size() !== 1) begin failures++; $display("FAIL csum_bad_wcount got=%0d exp=1", wr_addr.size()); end
  endtask
`endif

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    test_reset();
    test_len8();
    test_len5();
    test_len_zero();
    test_oversize();
    test_gaps();
    test_reset_mid();
    test_full_size();
`ifdef MEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    checks++; if (overlap !== 0) begin failures++; $display("FAIL we_with_core_release got=%0d exp=0", overlap); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
